// File: rtl/assembler_sequencer.sv
// Two-pass source streamer for the on-chip assembler: pass 1 feeds the parser for label/PC mapping,
// pass 2 re-feeds it and writes each encoded instruction into instruction memory.
module assembler_sequencer #(
   parameter int  SRC_DEPTH  = 4096,
   parameter int  IMEM_DEPTH = 1024,
   localparam int SRC_AW     = $clog2(SRC_DEPTH),
   localparam int IMEM_AW    = $clog2(IMEM_DEPTH)
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               start_in,
   input  logic [SRC_AW:0]    src_len_in,
   output logic [SRC_AW-1:0]  src_addr_out,
   input  logic [7:0]         src_data_in,
   output logic               char_valid_out,
   output logic [7:0]         char_out,
   input  logic               parser_ready_in,
   input  logic               line_done_in,
   input  logic               line_is_inst_in,
   input  logic               line_error_in,
   input  logic [31:0]        inst_in,
   output logic               pass_out,
   output logic [31:0]        pc_out,
   output logic               imem_we_out,
   output logic [IMEM_AW-1:0] imem_addr_out,
   output logic [31:0]        imem_data_out,
   output logic [1:0]         state_out,
   output logic               busy_out,
   output logic               done_out,
   output logic               error_out,
   output logic [15:0]        error_line_out,
   output logic [IMEM_AW:0]   inst_count_out
);

   localparam logic [31:0] IMEM_BYTES = 32'(4 * IMEM_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PC_MAP   = 2'd1,
      S_INST_MAP = 2'd2,
      S_ERROR    = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [SRC_AW:0]   len_q, fidx;
   logic              fetch_done;
   logic              rd_valid, rd_last;
   logic              skid_valid, skid_last;
   logic [7:0]        skid_data;
   logic [31:0]       pc;
   logic [15:0]       line_cnt, error_line;
   logic [IMEM_AW:0]  inst_count;
   logic              done_q;

   logic       busy, occ, xfer, issue, cur_last, pass_end, start_ok;
   logic       line_evt, inst_inc, overflow, fail, write_ok;
   logic [7:0] cur_char;

   // Handshake: a character moves to the parser in every cycle where char_valid_out and
   // parser_ready_in are both high; char_out is stable while valid is held without ready.
   // At most one byte is ever buffered: either the BRAM read in flight or the skid copy.
   assign busy     = (state == S_PC_MAP) || (state == S_INST_MAP);
   assign occ      = skid_valid | rd_valid;
   assign cur_char = skid_valid ? skid_data : (rd_last ? 8'h0A : src_data_in);
   assign cur_last = skid_valid ? skid_last : rd_last;
   assign xfer     = busy & occ & parser_ready_in;
   assign issue    = busy & !fetch_done & (!occ | parser_ready_in);
   assign pass_end = xfer & cur_last;
   assign start_ok = start_in & ((state == S_IDLE) || (state == S_ERROR));

   assign line_evt = busy & line_done_in;
   assign inst_inc = line_evt & line_is_inst_in;
   assign overflow = (state == S_INST_MAP) & inst_inc & !line_error_in & (pc == IMEM_BYTES);
   assign fail     = (line_evt & line_error_in) | overflow;
   assign write_ok = (state == S_INST_MAP) & inst_inc & !line_error_in & !overflow;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_ERROR: if (start_in) state_nxt = S_PC_MAP;
         S_PC_MAP: begin
            if (fail)          state_nxt = S_ERROR;
            else if (pass_end) state_nxt = S_INST_MAP;
         end
         S_INST_MAP: begin
            if (fail)          state_nxt = S_ERROR;
            else if (pass_end) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy_out       = busy;
      error_out      = (state == S_ERROR);
      pass_out       = (state == S_INST_MAP);
      state_out      = state;
      char_valid_out = busy & occ;
      char_out       = (busy & occ) ? cur_char : 8'h00;
      imem_we_out    = write_ok;
      imem_addr_out  = pc[IMEM_AW+1:2];
      imem_data_out  = write_ok ? inst_in : 32'h0;
      src_addr_out   = fidx[SRC_AW-1:0];
      pc_out         = pc;
      done_out       = done_q;
      error_line_out = error_line;
      inst_count_out = inst_count;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         len_q      <= '0;
         fidx       <= '0;
         fetch_done <= 1'b0;
         rd_valid   <= 1'b0;
         rd_last    <= 1'b0;
         skid_valid <= 1'b0;
         skid_last  <= 1'b0;
         skid_data  <= 8'h00;
         pc         <= 32'h0;
         line_cnt   <= 16'h0;
         error_line <= 16'h0;
         inst_count <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_ok) begin
            len_q      <= src_len_in;
            fidx       <= '0;
            fetch_done <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            pc         <= 32'h0;
            line_cnt   <= 16'h0;
            error_line <= 16'h0;
         end else if (busy) begin
            if (fail) begin
               error_line <= line_cnt + 16'd1;
               rd_valid   <= 1'b0;
               skid_valid <= 1'b0;
            end else if (pass_end) begin
               fidx       <= '0;
               fetch_done <= 1'b0;
               rd_valid   <= 1'b0;
               rd_last    <= 1'b0;
               skid_valid <= 1'b0;
               skid_last  <= 1'b0;
               pc         <= 32'h0;
               line_cnt   <= 16'h0;
               if (state == S_INST_MAP) begin
                  done_q     <= 1'b1;
                  inst_count <= pc[IMEM_AW+2:2] + {{IMEM_AW{1'b0}}, inst_inc};
               end
            end else begin
               // Index len_q is the synthetic newline: no BRAM byte, but same one-cycle timing.
               if (issue) begin
                  if (fidx == len_q) fetch_done <= 1'b1;
                  else               fidx       <= fidx + 1'b1;
               end
               rd_valid   <= issue;
               rd_last    <= issue & (fidx == len_q);
               skid_valid <= occ & !parser_ready_in;
               skid_data  <= cur_char;
               skid_last  <= cur_last;
               if (line_evt) begin
                  line_cnt <= line_cnt + 16'd1;
                  if (line_is_inst_in) pc <= pc + 32'd4;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_assembler_sequencer.sv
// Bench for assembler_sequencer: BRAM and parser models around the DUT, random source text,
// and a line-level reference model predicting the character stream, imem writes and final status.
module tb_assembler_sequencer;

   localparam int SRC_DEPTH  = 256;
   localparam int IMEM_DEPTH = 4;
   localparam int SRC_AW     = $clog2(SRC_DEPTH);
   localparam int IMEM_AW    = $clog2(IMEM_DEPTH);

   logic               clk_in = 1'b0;
   logic               rst_in;
   logic               start_in;
   logic [SRC_AW:0]    src_len_in;
   logic [SRC_AW-1:0]  src_addr_out;
   logic [7:0]         src_data_in;
   logic               char_valid_out;
   logic [7:0]         char_out;
   logic               parser_ready_in;
   logic               line_done_in;
   logic               line_is_inst_in;
   logic               line_error_in;
   logic [31:0]        inst_in;
   logic               pass_out;
   logic [31:0]        pc_out;
   logic               imem_we_out;
   logic [IMEM_AW-1:0] imem_addr_out;
   logic [31:0]        imem_data_out;
   logic [1:0]         state_out;
   logic               busy_out;
   logic               done_out;
   logic               error_out;
   logic [15:0]        error_line_out;
   logic [IMEM_AW:0]   inst_count_out;

   assembler_sequencer #(.SRC_DEPTH(SRC_DEPTH), .IMEM_DEPTH(IMEM_DEPTH)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .src_len_in(src_len_in),
      .src_addr_out(src_addr_out), .src_data_in(src_data_in),
      .char_valid_out(char_valid_out), .char_out(char_out), .parser_ready_in(parser_ready_in),
      .line_done_in(line_done_in), .line_is_inst_in(line_is_inst_in),
      .line_error_in(line_error_in), .inst_in(inst_in), .pass_out(pass_out), .pc_out(pc_out),
      .imem_we_out(imem_we_out), .imem_addr_out(imem_addr_out), .imem_data_out(imem_data_out),
      .state_out(state_out), .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
      .error_line_out(error_line_out), .inst_count_out(inst_count_out)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_in = ~clk_in;

   // ---------------- environment models ----------------
   logic [7:0]  src_mem   [0:SRC_DEPTH-1];
   bit          line_inst [0:511];
   bit          line_err  [0:511];
   logic [31:0] line_word [0:511];
   int          cur_len;
   int          ready_pct;
   int          tb_char, tb_line;

   always @(posedge clk_in) src_data_in <= src_mem[src_addr_out];

   assign line_done_in    = char_valid_out & parser_ready_in & (char_out == 8'h0A);
   assign line_is_inst_in = line_done_in & line_inst[tb_line];
   assign line_error_in   = line_done_in & line_err[tb_line];
   assign inst_in         = line_word[tb_line];

   // Parser-side position: the (cur_len+1)th character of a pass is the synthetic newline.
   always @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         tb_char <= 0;
         tb_line <= 0;
      end else if (start_in) begin
         tb_char <= 0;
         tb_line <= 0;
      end else if (char_valid_out && parser_ready_in) begin
         if (tb_char == cur_len) begin
            tb_char <= 0;
            tb_line <= 0;
         end else begin
            tb_char <= tb_char + 1;
            if (char_out == 8'h0A) tb_line <= tb_line + 1;
         end
      end
   end

   initial begin
      parser_ready_in = 1'b1;
      forever begin
         @(posedge clk_in);
         #1;
         parser_ready_in = ($urandom_range(99) < ready_pct);
      end
   end

   // ---------------- scoreboard ----------------
   logic [7:0]  got_chars[$], exp_chars[$];
   logic [31:0] got_waddr[$], got_wdata[$], got_wpc[$];
   logic [31:0] exp_waddr[$], exp_wdata[$], exp_wpc[$];
   bit          exp_done, exp_err;
   int          exp_err_line, exp_count;
   int          vectors, miscompares;

   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (char_valid_out && parser_ready_in) got_chars.push_back(char_out);
         if (imem_we_out) begin
            got_waddr.push_back(32'(imem_addr_out));
            got_wdata.push_back(imem_data_out);
            got_wpc.push_back(pc_out);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: walk the character stream line by line, applying the two-pass rules directly.
   task automatic build_expect();
      logic [7:0] s[$];
      int line, pc;
      bit stop;
      exp_chars.delete(); exp_waddr.delete(); exp_wdata.delete(); exp_wpc.delete();
      exp_done = 0; exp_err = 0; exp_err_line = 0; exp_count = 0;
      for (int i = 0; i < cur_len; i++) s.push_back(src_mem[i]);
      s.push_back(8'h0A);
      line = 0;
      stop = 0;
      for (int i = 0; i < s.size() && !stop; i++) begin
         exp_chars.push_back(s[i]);
         if (s[i] == 8'h0A) begin
            if (line_err[line]) begin exp_err = 1; exp_err_line = line + 1; stop = 1; end
            line++;
         end
      end
      if (exp_err) return;
      line = 0;
      pc = 0;
      for (int i = 0; i < s.size() && !stop; i++) begin
         exp_chars.push_back(s[i]);
         if (s[i] == 8'h0A) begin
            if (line_err[line]) begin
               exp_err = 1; exp_err_line = line + 1; stop = 1;
            end else if (line_inst[line]) begin
               if (pc == 4 * IMEM_DEPTH) begin
                  exp_err = 1; exp_err_line = line + 1; stop = 1;
               end else begin
                  exp_waddr.push_back(32'(pc / 4));
                  exp_wdata.push_back(line_word[line]);
                  exp_wpc.push_back(32'(pc));
                  pc += 4;
               end
            end
            line++;
         end
      end
      if (!exp_err) begin exp_done = 1; exp_count = pc / 4; end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_lines();
      for (int j = 0; j < 512; j++) begin
         line_inst[j] = 0;
         line_err[j]  = 0;
         line_word[j] = $urandom;
      end
   endtask

   task automatic load_str(input string str);
      for (int i = 0; i < str.len(); i++) src_mem[i] = str[i];
      cur_len = str.len();
   endtask

   task automatic fill_random(input int len, input int nl_pct, input int inst_pct);
      for (int i = 0; i < len; i++)
         src_mem[i] = ($urandom_range(99) < nl_pct) ? 8'h0A : 8'(8'h61 + $urandom_range(25));
      cur_len = len;
      clear_lines();
      for (int j = 0; j < 512; j++) line_inst[j] = ($urandom_range(99) < inst_pct);
   endtask

   task automatic pulse_start();
      @(negedge clk_in);
      start_in   = 1'b1;
      src_len_in = (SRC_AW+1)'(cur_len);
      @(negedge clk_in);
      start_in   = 1'b0;
   endtask

   task automatic run_case(input string name, input int max_cycles);
      bit saw_done, saw_err;
      int cycles;
      build_expect();
      got_chars.delete(); got_waddr.delete(); got_wdata.delete(); got_wpc.delete();
      pulse_start();
      saw_done = 0; saw_err = 0; cycles = 0;
      for (int c = 0; c < 20000 && !saw_done && !saw_err; c++) begin
         @(negedge clk_in);
         cycles++;
         if (done_out)  saw_done = 1;
         if (error_out) saw_err  = 1;
      end
      if (!saw_done && !saw_err) check({name, ":timeout"}, 32'(1), 32'(0));
      check({name, ":cycles_ok"}, 32'(cycles <= max_cycles), 32'(1));
      repeat (3) @(negedge clk_in);
      check({name, ":done"}, 32'(saw_done), 32'(exp_done));
      check({name, ":state"}, 32'(state_out), exp_err ? 32'(3) : 32'(0));
      check({name, ":error_out"}, 32'(error_out), 32'(exp_err));
      check({name, ":error_line"}, 32'(error_line_out), 32'(exp_err_line));
      if (exp_done) check({name, ":inst_count"}, 32'(inst_count_out), 32'(exp_count));
      check({name, ":n_chars"}, 32'(got_chars.size()), 32'(exp_chars.size()));
      for (int i = 0; i < got_chars.size() && i < exp_chars.size(); i++)
         check({name, ":char"}, 32'(got_chars[i]), 32'(exp_chars[i]));
      check({name, ":n_writes"}, 32'(got_waddr.size()), 32'(exp_waddr.size()));
      for (int i = 0; i < got_waddr.size() && i < exp_waddr.size(); i++) begin
         check({name, ":waddr"}, got_waddr[i], exp_waddr[i]);
         check({name, ":wdata"}, got_wdata[i], exp_wdata[i]);
         check({name, ":wpc"}, got_wpc[i], exp_wpc[i]);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit reached;
      vectors = 0; miscompares = 0;
      ready_pct = 100;
      cur_len = 0;
      start_in = 1'b0;
      src_len_in = '0;
      for (int i = 0; i < SRC_DEPTH; i++) src_mem[i] = 8'h20;
      clear_lines();
      rst_in = 1'b1;
      #1;
      check("rst:state", 32'(state_out), 32'(0));
      check("rst:busy", 32'(busy_out), 32'(0));
      check("rst:char_valid", 32'(char_valid_out), 32'(0));
      check("rst:imem_we", 32'(imem_we_out), 32'(0));
      check("rst:pc", pc_out, 32'(0));
      check("rst:src_addr", 32'(src_addr_out), 32'(0));
      check("rst:done", 32'(done_out), 32'(0));
      check("rst:error_line", 32'(error_line_out), 32'(0));
      check("rst:inst_count", 32'(inst_count_out), 32'(0));
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;

      // Single instruction line, full throughput.
      load_str("addi x1,x0,5\n");
      clear_lines();
      line_inst[0] = 1;
      line_word[0] = 32'h00500093;
      run_case("single", 34);

      // Three lines without trailing newline.
      load_str("addi x1,x0,1\naddi x2,x0,2\naddi x3,x0,3");
      clear_lines();
      for (int j = 0; j < 3; j++) line_inst[j] = 1;
      run_case("three", 100);

      // Random text with the parser stalling half the time.
      ready_pct = 50;
      for (int k = 0; k < 4; k++) begin
         fill_random($urandom_range(20, 120), 4, 40);
         run_case("rand_stall", 5000);
      end

      // Syntax error on line 2 during pass 1, then restart from ERROR.
      ready_pct = 100;
      load_str("li x1,1\nbad\nnop\n");
      clear_lines();
      line_inst[0] = 1; line_inst[2] = 1;
      line_err[1] = 1;
      run_case("err_line2", 100);
      ready_pct = 70;
      fill_random($urandom_range(10, 60), 5, 30);
      run_case("restart", 5000);

      // More instructions than IMEM_DEPTH.
      ready_pct = 100;
      load_str("a\nb\nc\nd\ne");
      clear_lines();
      for (int j = 0; j < 5; j++) line_inst[j] = 1;
      run_case("overflow", 100);

      // Reset in the middle of pass 2.
      fill_random(60, 15, 0);
      line_inst[0] = 1; line_inst[1] = 1;
      pulse_start();
      reached = 0;
      for (int c = 0; c < 2000 && !reached; c++) begin
         @(negedge clk_in);
         if (pass_out) reached = 1;
      end
      check("midrst:reached_pass2", 32'(reached), 32'(1));
      repeat (5) @(negedge clk_in);
      rst_in = 1'b1;
      #1;
      check("midrst:state", 32'(state_out), 32'(0));
      check("midrst:busy", 32'(busy_out), 32'(0));
      check("midrst:char_valid", 32'(char_valid_out), 32'(0));
      check("midrst:imem_we", 32'(imem_we_out), 32'(0));
      check("midrst:pc", pc_out, 32'(0));
      @(negedge clk_in);
      rst_in = 1'b0;
      got_chars.delete(); got_waddr.delete(); got_wdata.delete(); got_wpc.delete();
      repeat (30) @(negedge clk_in);
      check("midrst:no_writes", 32'(got_waddr.size()), 32'(0));
      check("midrst:no_chars", 32'(got_chars.size()), 32'(0));
      check("midrst:idle", 32'(state_out), 32'(0));

      // Empty source: only the synthetic newline per pass.
      cur_len = 0;
      clear_lines();
      run_case("empty", 20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
